mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the core's read/write request interface; serves the
//   core's read_en/read_addr and write_en/write_addr/data strobes from an internal
//   word RAM. Sits beside the core inside top as the simulation and FPGA backing store.
//   Zero-fills the RAM after reset, then returns read data over a fixed-latency pipeline.
// PARAMETERS
//   DATA_W        32   data word width (bits)
//   ADDR_W        32   request address width (word address, not byte)
//   DEPTH         1024 RAM words; valid addresses 0..DEPTH-1
//   READ_LATENCY  1    cycles from read request to o_rd_valid; legal 1..4
// PORTS
//   i_clk         in   1       single clock, all logic on rising edge
//   i_rst_n       in   1       asynchronous active-low reset
//   i_read_en     in   1       read request strobe, one request per cycle
//   i_read_addr   in   ADDR_W  read word address
//   i_write_en    in   1       write request strobe
//   i_write_addr  in   ADDR_W  write word address
//   i_data        in   DATA_W  write data
//   o_data        out  DATA_W  read data, qualified by o_rd_valid
//   o_rd_valid    out  1       one-cycle strobe per accepted read
//   o_ready       out  1       high once INIT sweep finishes; requests accepted only when high
//   o_err         out  1       one-cycle strobe: accepted request hit address >= DEPTH
// BEHAVIOUR
//   Reset (i_rst_n low, async): o_data=0, o_rd_valid=0, o_ready=0, o_err=0,
//     read pipeline flushed, init counter=0, FSM=INIT. RAM contents not reset directly.
//   FSM INIT: each cycle writes 0 to RAM[cnt], cnt++; after cnt==DEPTH-1 is written,
//     next state RUN. o_ready rises the cycle after the final clear write (DEPTH cycles
//     after reset release). Requests during INIT are dropped silently (no valid, no err).
//   FSM RUN: o_ready=1; remains in RUN until reset. No other transitions.
//   Write: i_write_en && o_ready at edge -> RAM[i_write_addr]<=i_data. Out of range:
//     write dropped, o_err=1 the next cycle.
//   Read: i_read_en && o_ready at edge N -> o_rd_valid=1 and o_data=word during cycle
//     N+READ_LATENCY. Fully pipelined: back-to-back reads give back-to-back valids.
//     Out of range: o_data=0, o_rd_valid still asserted, o_err=1 the same cycle as valid.
//   o_data holds its last value while o_rd_valid=0.
//   Same-cycle read and write to the same address: read returns NEW data (write-first).
//     Read of an address written in a later cycle, while that read is still in the
//     pipeline, returns the value at the read's request cycle (RAM sampled at request).
//   Read and write to different addresses in the same cycle are both serviced.
//   Read and write both out of range in the same cycle: o_err asserted at the
//     earlier of the two strobe cycles and again at the later one if distinct.
//   Address compare uses full ADDR_W; upper bits are never silently truncated.
//   Reset mid-operation: in-flight reads are discarded (no valid); FSM re-runs INIT.
// TESTING
//   Reset, hold requests: o_ready=0 for exactly DEPTH cycles, then 1; read addr 5 -> 0.
//   Write 0xA5A5_0001 @3, read @3 next cycle -> o_data=0xA5A5_0001, valid at +READ_LATENCY.
//   Same-cycle write 0x1234 @7 + read @7 -> o_data=0x1234 (write-first).
//   Reads @0,1,2,3 back-to-back with READ_LATENCY=3 -> four consecutive valids, in order.
//   Read @DEPTH -> o_data=0, o_rd_valid=1, o_err=1; write @DEPTH -> RAM unchanged, o_err=1.
//   Read issued, i_rst_n pulsed low before valid -> no o_rd_valid; INIT restarts, RAM zeroed.

Source files
------------

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - word RAM responder for core read/write requests
//
// Purpose:
//   Backing store for the core's request interface. After reset the RAM is
//   swept to zero, one word per cycle, and o_ready rises once the sweep ends.
//   Writes land in the RAM at the request edge. Reads sample the RAM at the
//   request edge and come out of a READ_LATENCY-deep pipeline. A write to the
//   same address in the same cycle is visible to that read (write-first).
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_read_en     read request strobe
//   i_read_addr   read word address (ADDR_W bits)
//   i_write_en    write request strobe
//   i_write_addr  write word address (ADDR_W bits)
//   i_data        write data
//   o_data        read data; holds the last returned word between valids
//   o_rd_valid    one-cycle strobe per accepted read
//   o_ready       requests are accepted only while high
//   o_err         one-cycle strobe for an accepted out-of-range request
module mem_responder #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 32,
  parameter int DEPTH        = 1024,
  parameter int READ_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_read_en,
  input  logic [ADDR_W-1:0] i_read_addr,
  input  logic              i_write_en,
  input  logic [ADDR_W-1:0] i_write_addr,
  input  logic [DATA_W-1:0] i_data,
  output logic [DATA_W-1:0] o_data,
  output logic              o_rd_valid,
  output logic              o_ready,
  output logic              o_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable even when it equals 2**ADDR_W.
  localparam logic [ADDR_W:0]  DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_e;

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              ready_q;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              pipe_vld_q [READ_LATENCY];
  logic              pipe_err_q [READ_LATENCY];
  logic [DATA_W-1:0] pipe_dat_q [READ_LATENCY];
  logic              wr_err_q;

  logic              rd_req, wr_req;
  logic              rd_in_range, wr_in_range;
  logic              wr_ok;
  logic [IDX_W-1:0]  rd_idx, wr_idx;
  logic [DATA_W-1:0] rd_word;

  assign rd_req      = i_read_en && ready_q;
  assign wr_req      = i_write_en && ready_q;
  // Range check on the full address: an address such as 2**ADDR_W-1 must not
  // alias onto a low RAM word through the index bits.
  assign rd_in_range = {1'b0, i_read_addr} < DEPTH_X;
  assign wr_in_range = {1'b0, i_write_addr} < DEPTH_X;
  assign wr_ok       = wr_req && wr_in_range;
  assign rd_idx      = i_read_addr[IDX_W-1:0];
  assign wr_idx      = i_write_addr[IDX_W-1:0];

  // Word captured into the pipeline. Out-of-range reads return zero. A
  // same-cycle write to the same address bypasses the RAM (write-first).
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      if (wr_ok && (i_write_addr == i_read_addr)) begin
        rd_word = i_data;
      end else begin
        rd_word = mem_q[rd_idx];
      end
    end
  end

  // Control FSM: a zeroing sweep, then RUN until the next reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_IDX) begin
            state_q <= ST_RUN;
            ready_q <= 1'b1;
          end
        end
        ST_RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  // RAM array. It has no reset, so it can map onto block or distributed RAM.
  // The INIT sweep clears it. ready_q is low during INIT, so user writes
  // never compete with the sweep.
  always_ff @(posedge i_clk) begin
    if (state_q == ST_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_idx] <= i_data;
    end
  end

  // Read pipeline. A stage's data register loads only when a valid enters
  // it, so the last stage holds the most recent returned word for o_data.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= 1'b0;
        pipe_err_q[i] <= 1'b0;
        pipe_dat_q[i] <= '0;
      end
      wr_err_q <= 1'b0;
    end else begin
      pipe_vld_q[0] <= rd_req;
      pipe_err_q[0] <= rd_req && !rd_in_range;
      if (rd_req) begin
        pipe_dat_q[0] <= rd_word;
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
        pipe_vld_q[i] <= pipe_vld_q[i-1];
        pipe_err_q[i] <= pipe_err_q[i-1];
        if (pipe_vld_q[i-1]) begin
          pipe_dat_q[i] <= pipe_dat_q[i-1];
        end
      end
      wr_err_q <= wr_req && !wr_in_range;
    end
  end

  assign o_ready    = ready_q;
  assign o_rd_valid = pipe_vld_q[READ_LATENCY-1];
  assign o_data     = pipe_dat_q[READ_LATENCY-1];
  // A write error and a read error that land in the same cycle merge into one strobe.
  assign o_err      = wr_err_q | pipe_err_q[READ_LATENCY-1];

endmodule

// File: tb/tb_mem_responder.sv
// tb/tb_mem_responder.sv - self-checking bench for mem_responder
module tb_mem_responder;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 64;
  localparam int LAT   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          read_en = 1'b0;
  logic [AW-1:0] read_addr = '0;
  logic          write_en = 1'b0;
  logic [AW-1:0] write_addr = '0;
  logic [DW-1:0] wdata = '0;
  logic [DW-1:0] o_data;
  logic          o_rd_valid, o_ready, o_err;

  always #5 clk = ~clk;

  mem_responder #(
    .DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .READ_LATENCY(LAT)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_read_en(read_en), .i_read_addr(read_addr),
    .i_write_en(write_en), .i_write_addr(write_addr), .i_data(wdata),
    .o_data(o_data), .o_rd_valid(o_rd_valid), .o_ready(o_ready), .o_err(o_err)
  );

  int total = 0;
  int bad = 0;
  int cur = 0;

  logic [DW-1:0] mdl_mem [DEPTH];
  logic [DW-1:0] exp_dat [int];
  bit            exp_err [int];
  logic [DW-1:0] last_data;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cur, obs, exp);
    end
  endtask

  task automatic check_cycle();
    bit ev;
    ev = exp_dat.exists(cur);
    if (ev) last_data = exp_dat[cur];
    chk("ready", 32'(o_ready), 32'(cur >= DEPTH));
    chk("rd_valid", 32'(o_rd_valid), 32'(ev));
    chk("err", 32'(o_err), 32'(exp_err.exists(cur)));
    chk("data", o_data, last_data);
  endtask

  // One request cycle. The model applies the write first, so a same-cycle
  // read sees it. It then snapshots the read result for cycle cur+LAT.
  task automatic step(input bit re, input logic [AW-1:0] ra, input bit we,
                      input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    read_en = re; read_addr = ra; write_en = we; write_addr = wa; wdata = wd;
    if (cur >= DEPTH) begin
      if (we) begin
        if (wa < DEPTH) mdl_mem[int'(wa)] = wd;
        else exp_err[cur + 1] = 1'b1;
      end
      if (re) begin
        if (ra < DEPTH) exp_dat[cur + LAT] = mdl_mem[int'(ra)];
        else begin
          exp_dat[cur + LAT] = '0;
          exp_err[cur + LAT] = 1'b1;
        end
      end
    end
    @(posedge clk);
    cur++;
    @(negedge clk);
    check_cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
  endtask

  task automatic do_reset(input int hold);
    read_en = 1'b0; write_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_rd_valid), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_data", o_data, 32'd0);
    repeat (hold) @(negedge clk);
    exp_dat.delete();
    exp_err.delete();
    for (int i = 0; i < DEPTH; i++) mdl_mem[i] = '0;
    last_data = '0;
    cur = 0;
    rst_n = 1'b1;
    check_cycle();
  endtask

  function automatic logic [AW-1:0] rnd_addr();
    case ($urandom_range(0, 9))
      0: return AW'(DEPTH + $urandom_range(0, 2));
      1: return 32'hFFFF_0000 | AW'($urandom_range(0, 9));
      default: return AW'($urandom_range(0, 9));
    endcase
  endfunction

  initial begin
    @(negedge clk);
    do_reset(2);

    // Random requests during INIT are dropped; o_ready must stay low for DEPTH cycles.
    for (int i = 0; i < DEPTH; i++)
      step(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);

    step(1'b1, 32'd5, 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, 32'd3, 32'hA5A5_0001);
    step(1'b1, 32'd3, 1'b0, '0, '0);
    step(1'b1, 32'd7, 1'b1, 32'd7, 32'h0000_1234);
    for (int i = 0; i < 4; i++) step(1'b1, AW'(i), 1'b0, '0, '0);
    step(1'b1, AW'(DEPTH), 1'b0, '0, '0);
    step(1'b0, '0, 1'b1, AW'(DEPTH), 32'hDEAD_BEEF);
    step(1'b1, 32'd0, 1'b0, '0, '0);
    step(1'b1, AW'(DEPTH + 1), 1'b1, 32'hFFFF_0003, 32'h0BAD_0BAD);
    step(1'b1, 32'd3, 1'b0, '0, '0);
    idle(LAT + 1);

    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), rnd_addr(), 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
    idle(LAT + 1);

    // Read in flight when reset hits: no valid may appear, and the RAM reads zero afterwards.
    step(1'b0, '0, 1'b1, 32'd3, 32'h5555_AAAA);
    step(1'b1, 32'd3, 1'b0, '0, '0);
    do_reset(1);
    idle(DEPTH);
    step(1'b1, 32'd3, 1'b0, '0, '0);
    step(1'b1, 32'd7, 1'b0, '0, '0);
    idle(LAT + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
